// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding logic.
//   REG_W / REG_ZERO : register address width and the hard-wired zero register
//   FWD_*            : EX operand select encodings (regfile, WB data, MEM ALU result)
//   dest_slot_t      : one in-flight destination (address, write flag, load flag)
//   hz_mode_e        : pipe control mode, in priority order freeze > load-use > run
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [REG_W-1:0] wr_reg;
        logic             reg_write;
        logic             is_load;
    } dest_slot_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_LU_STALL,
        MODE_FREEZE
    } hz_mode_e;

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Combinational forwarding select for one EX operand.
//   src_i                    : EX-stage source register
//   mem_wr_reg_i / mem_we_i  : destination held in the MEM slot
//   wb_wr_reg_i  / wb_we_i   : destination held in the WB slot
//   sel_o                    : FWD_MEM, FWD_WB or FWD_RF
module fwd_select
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] mem_wr_reg_i,
    input  logic             mem_we_i,
    input  logic [REG_W-1:0] wb_wr_reg_i,
    input  logic             wb_we_i,
    output logic [1:0]       sel_o
);

    // MEM is checked first: it holds the most recent write to the register.
    always_comb begin
        sel_o = FWD_RF;
        if (mem_we_i && (mem_wr_reg_i != REG_ZERO) && (mem_wr_reg_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_wr_reg_i != REG_ZERO) && (wb_wr_reg_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks EX destinations through MEM and WB, drives the operand forwarding
// selects, inserts one bubble on a load-use hazard and freezes the pipe while
// data memory is busy. stall_cycles counts stalled/frozen cycles, saturating.
//   inputs : clk, reset (sync, active-high), ID sources + use flags,
//            EX sources/destination/control, mem_busy
//   outputs: pc/ifid/idex write enables, idex_bubble, fwd_a, fwd_b, stall_cycles
module hazard_fwd_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_wr_reg,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             mem_busy,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    import pipe_pkg::*;

    dest_slot_t       mem_q, mem_d;
    logic [REG_W-1:0] wb_wr_reg_q, wb_wr_reg_d;
    logic             wb_we_q, wb_we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             luh;
    hz_mode_e         mode;

    assign luh = ex_mem_read && ex_reg_write && (ex_wr_reg != REG_ZERO) &&
                 ((id_uses_rs && (id_rs == ex_wr_reg)) ||
                  (id_uses_rt && (id_rt == ex_wr_reg)));

    always_comb begin
        if (mem_busy)  mode = MODE_FREEZE;
        else if (luh)  mode = MODE_LU_STALL;
        else           mode = MODE_RUN;
    end

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        idex_write_en = 1'b1;
        idex_bubble   = 1'b0;
        mem_d         = mem_q;
        wb_wr_reg_d   = wb_wr_reg_q;
        wb_we_d       = wb_we_q;
        cnt_d         = cnt_q;
        if (mode != MODE_RUN && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (mode)
            MODE_FREEZE: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_write_en = 1'b0;
            end
            MODE_LU_STALL: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_bubble   = 1'b1;
            end
            default: ;
        endcase
        // The load itself still advances during a load-use stall; only
        // the front of the pipe is held.
        if (mode != MODE_FREEZE) begin
            mem_d.wr_reg    = ex_wr_reg;
            mem_d.reg_write = ex_reg_write;
            mem_d.is_load   = ex_mem_read;
            wb_wr_reg_d     = mem_q.wr_reg;
            wb_we_d         = mem_q.reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '0;
            wb_wr_reg_q <= '0;
            wb_we_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mem_q       <= mem_d;
            wb_wr_reg_q <= wb_wr_reg_d;
            wb_we_q     <= wb_we_d;
            cnt_q       <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .src_i        (ex_rs),
        .mem_wr_reg_i (mem_q.wr_reg),
        .mem_we_i     (mem_q.reg_write),
        .wb_wr_reg_i  (wb_wr_reg_q),
        .wb_we_i      (wb_we_q),
        .sel_o        (fwd_a)
    );

    fwd_select u_fwd_b (
        .src_i        (ex_rt),
        .mem_wr_reg_i (mem_q.wr_reg),
        .mem_we_i     (mem_q.reg_write),
        .wb_wr_reg_i  (wb_wr_reg_q),
        .wb_we_i      (wb_we_q),
        .sel_o        (fwd_b)
    );

    assign stall_cycles = cnt_q;

    // A load in MEM has no data yet; the load-use bubble must have
    // prevented any consumer from selecting it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_q.is_load && mem_q.reg_write &&
                      (fwd_a == FWD_MEM || fwd_b == FWD_MEM)));
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_reg;
    logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, mem_busy;
    logic       pc_write_en, ifid_write_en, idex_write_en, idex_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model: the two in-flight writers, newest first, and a counter.
    logic [4:0]  m_reg [2];
    bit          m_we  [2];
    bit          m_ld;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_reg(ex_wr_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_busy(mem_busy),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .idex_write_en(idex_write_en), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        for (int i = 0; i < 2; i++)
            if (m_we[i] && m_reg[i] != 0 && m_reg[i] == src)
                return (i == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_luh();
        return ex_mem_read && ex_reg_write && ex_wr_reg != 0 &&
               ((id_uses_rs && id_rs == ex_wr_reg) || (id_uses_rt && id_rt == ex_wr_reg));
    endfunction

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_wr_reg = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_busy = 0;
    endtask

    task automatic sample(input bit full);
        bit stall;
        @(negedge clk);
        if (full) begin
            stall = !mem_busy && exp_luh();
            chk("pc_write_en",   pc_write_en,   !(mem_busy || stall));
            chk("ifid_write_en", ifid_write_en, !(mem_busy || stall));
            chk("idex_write_en", idex_write_en, !mem_busy);
            chk("idex_bubble",   idex_bubble,   stall);
            chk("fwd_a",         fwd_a,         exp_fwd(ex_rs));
            chk("fwd_b",         fwd_b,         exp_fwd(ex_rt));
            chk("stall_cycles",  stall_cycles,  m_cnt);
        end
    endtask

    task automatic advance();
        bit stall;
        @(posedge clk);
        stall = !mem_busy && exp_luh();
        if (reset) begin
            m_reg[0] = 0; m_reg[1] = 0; m_we[0] = 0; m_we[1] = 0; m_ld = 0; m_cnt = 0;
        end else begin
            if ((mem_busy || stall) && m_cnt < 65535) m_cnt++;
            if (!mem_busy) begin
                m_reg[1] = m_reg[0]; m_we[1] = m_we[0];
                m_reg[0] = ex_wr_reg; m_we[0] = ex_reg_write; m_ld = ex_mem_read;
            end
        end
        #1;
    endtask

    task automatic step();
        sample(1'b1);
        advance();
    endtask

    initial begin
        m_reg[0] = 0; m_reg[1] = 0; m_we[0] = 0; m_we[1] = 0; m_ld = 0; m_cnt = 0;
        idle();
        reset = 1;
        advance(); advance();
        reset = 0;

        // Idle after reset
        sample(1'b1);
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_pc_en", pc_write_en, 1'b1);
        chk("rst_bubble", idex_bubble, 1'b0);
        chk("rst_cnt", stall_cycles, 16'd0);
        advance();

        // add r8, then consumers one and two cycles later
        ex_wr_reg = 8; ex_reg_write = 1;
        step();
        idle(); ex_rs = 8;
        sample(1'b1); chk("mem_fwd_a", fwd_a, 2'b10); advance();
        idle(); ex_rt = 8;
        sample(1'b1); chk("wb_fwd_b", fwd_b, 2'b01); advance();

        // lw r9 followed by a dependent instruction in ID
        idle(); ex_wr_reg = 9; ex_reg_write = 1; ex_mem_read = 1; id_rs = 9; id_uses_rs = 1;
        sample(1'b1);
        chk("lu_pc_en", pc_write_en, 1'b0);
        chk("lu_ifid_en", ifid_write_en, 1'b0);
        chk("lu_bubble", idex_bubble, 1'b1);
        advance();
        idle(); id_rs = 9; id_uses_rs = 1;   // bubble now in EX
        sample(1'b1);
        chk("lu_one_bubble", idex_bubble, 1'b0);
        chk("lu_cnt", stall_cycles, 16'd1);
        advance();
        idle(); ex_rs = 9;
        sample(1'b1); chk("lu_fwd_wb", fwd_a, 2'b01); advance();

        // back-to-back writes to r5, then writes to r0
        idle(); ex_wr_reg = 5; ex_reg_write = 1;
        step(); step();
        idle(); ex_rs = 5;
        sample(1'b1); chk("mem_prio", fwd_a, 2'b10); advance();
        idle(); ex_wr_reg = 0; ex_reg_write = 1;
        step(); step();
        idle(); ex_rs = 0; ex_rt = 0;
        sample(1'b1); chk("r0_no_fwd", fwd_a, 2'b00); advance();

        // Freeze with r7 in MEM and a load-use pattern on the inputs
        idle(); ex_wr_reg = 7; ex_reg_write = 1;
        step();
        idle(); mem_busy = 1; ex_rs = 7;
        ex_wr_reg = 3; ex_reg_write = 1; ex_mem_read = 1; id_rs = 3; id_uses_rs = 1;
        for (int i = 0; i < 3; i++) begin
            sample(1'b1);
            chk("frz_fwd_a", fwd_a, 2'b10);
            chk("frz_idex_en", idex_write_en, 1'b0);
            chk("frz_bubble", idex_bubble, 1'b0);
            advance();
        end
        idle();
        sample(1'b1); chk("frz_cnt", stall_cycles, 16'd4); advance();

        // Saturation, then reset in the middle of the freeze
        idle(); ex_wr_reg = 12; ex_reg_write = 1;
        step();
        idle(); mem_busy = 1; ex_rs = 12;
        for (int i = 0; i < 65541; i++) begin
            sample(1'b0);
            advance();
        end
        sample(1'b1); chk("sat_cnt", stall_cycles, 16'hFFFF); chk("sat_fwd", fwd_a, 2'b10);
        advance();
        reset = 1;
        step();
        reset = 0;
        sample(1'b1);
        chk("rst_frz_cnt", stall_cycles, 16'd0);
        chk("rst_frz_fwd", fwd_a, 2'b00);
        chk("rst_frz_en", pc_write_en, 1'b0);
        advance();
        idle();
        sample(1'b1); chk("post_rst_en", pc_write_en, 1'b1); advance();

        // Randomized traffic with small register indices to force collisions
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            mem_busy     = ($urandom_range(0, 4) == 0);
            id_rs        = 5'($urandom_range(0, 7));
            id_rt        = 5'($urandom_range(0, 7));
            id_uses_rs   = 1'($urandom);
            id_uses_rt   = 1'($urandom);
            ex_wr_reg    = 5'($urandom_range(0, 7));
            ex_reg_write = 1'($urandom);
            ex_mem_read  = 1'($urandom);
            ex_rs        = 5'($urandom_range(0, 7));
            ex_rt        = 5'($urandom_range(0, 7));
            // A real pipeline never has a consumer directly behind a load in MEM.
            if (m_ld && m_we[0] && m_reg[0] != 0) begin
                while (ex_rs == m_reg[0]) ex_rs = 5'($urandom_range(0, 7));
                while (ex_rt == m_reg[0]) ex_rt = 5'($urandom_range(0, 7));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
